// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one iterative shift-and-add multiplier
// among NUM_REQ requesters. A per-request const_time bit disables the
// zero-operand early exit so that latency does not depend on operand data.
module mul_share_sched #(
   parameter int WIDTH   = 4,
   parameter int NUM_REQ = 2,
   parameter int ID_W    = $clog2(NUM_REQ),
   parameter int CNT_W   = $clog2(WIDTH) + 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*WIDTH-1:0]   req_b,
   input  logic [NUM_REQ-1:0]         req_const_time,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic [2*WIDTH-1:0]         resp_o,
   output logic [ID_W-1:0]            resp_id,
   output logic [CNT_W:0]             resp_cycles,
   output logic                       busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state;
   logic [WIDTH-1:0]    a_reg;
   logic [WIDTH-1:0]    b_reg;
   logic [2*WIDTH-1:0]  o_reg;
   logic [CNT_W-1:0]    counter;
   logic [CNT_W:0]      cycles;
   logic [ID_W-1:0]     id_reg;
   logic                ct_reg;
   logic [ID_W-1:0]     rr_ptr;

   logic                grant_found;
   logic [ID_W-1:0]     grant;
   logic                exit_now;
   logic [2*WIDTH-1:0]  addend;

   // Round-robin search starting just after the last granted requester
   always_comb begin
      int idx;
      grant_found = 1'b0;
      grant       = '0;
      idx         = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!grant_found && req_valid[idx[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant       = idx[ID_W-1:0];
         end
      end
   end

   // Accept strobe is only offered while idle, and only to the winner
   always_comb begin
      req_ready = '0;
      if (state == IDLE && grant_found)
         req_ready[grant] = 1'b1;
   end

   // Exit test and partial product for the current RUN cycle
   always_comb begin
      exit_now = ct_reg ? (counter == CNT_W'(WIDTH))
                        : (a_reg == '0 || b_reg == '0);
      addend   = b_reg[0] ? ({{WIDTH{1'b0}}, a_reg} << counter) : '0;
   end

   // Scheduler FSM, multiplier datapath and registered response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         a_reg       <= '0;
         b_reg       <= '0;
         o_reg       <= '0;
         counter     <= '0;
         cycles      <= '0;
         id_reg      <= '0;
         ct_reg      <= 1'b0;
         rr_ptr      <= ID_W'(NUM_REQ - 1);
         resp_o      <= '0;
         resp_id     <= '0;
         resp_cycles <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  a_reg   <= req_a[int'(grant)*WIDTH +: WIDTH];
                  b_reg   <= req_b[int'(grant)*WIDTH +: WIDTH];
                  ct_reg  <= req_const_time[grant];
                  id_reg  <= grant;
                  o_reg   <= '0;
                  counter <= '0;
                  cycles  <= '0;
                  rr_ptr  <= grant;
                  state   <= RUN;
               end
            end
            RUN: begin
               cycles <= cycles + 1'b1;
               if (exit_now) begin
                  // Result registers keep the last completed values until the next finish
                  resp_o      <= o_reg;
                  resp_id     <= id_reg;
                  resp_cycles <= cycles + 1'b1;
                  state       <= DONE;
               end else begin
                  o_reg   <= o_reg + addend;
                  b_reg   <= b_reg >> 1;
                  counter <= counter + 1'b1;
               end
            end
            DONE: begin
               if (resp_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign resp_valid = (state == DONE);
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_mul_share_sched.sv
// Self-checking bench for mul_share_sched: vector table, exhaustive sweeps,
// randomized operations against a behavioural model, and hand-written
// sequences for round-robin, response stall and mid-operation reset.
module tb_mul_share_sched;

   localparam int WIDTH   = 4;
   localparam int NUM_REQ = 2;
   localparam int ID_W    = 1;
   localparam int CNT_W   = 3;

   logic                     clk;
   logic                     rst_n;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic [NUM_REQ-1:0]       req_const_time;
   logic                     resp_valid;
   logic                     resp_ready;
   logic [2*WIDTH-1:0]       resp_o;
   logic [ID_W-1:0]          resp_id;
   logic [CNT_W:0]           resp_cycles;
   logic                     busy;

   int total = 0;
   int bad   = 0;
   int last_grant;

   mul_share_sched #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_const_time(req_const_time),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_o(resp_o), .resp_id(resp_id), .resp_cycles(resp_cycles),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int id;
      int a;
      int b;
      bit ct;
      int exp_o;
      int exp_cyc;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference latency from the operand rules: the multiplier walks b up to its top set bit
   function automatic int model_cycles(input int a, input int b, input bit ct);
      if (ct) return WIDTH + 1;
      if (a == 0 || b == 0) return 1;
      return $clog2(b + 1) + 1;
   endfunction

   // Present a single request, wait for its grant and complete the handshake
   task automatic start_op(input int id, input int a, input int b, input bit ct);
      int n;
      @(negedge clk);
      req_valid = '0;
      req_valid[id] = 1'b1;
      req_a[id*WIDTH +: WIDTH] = a[WIDTH-1:0];
      req_b[id*WIDTH +: WIDTH] = b[WIDTH-1:0];
      req_const_time[id] = ct;
      #1;
      n = 0;
      while (!req_ready[id] && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      check("grant", req_ready, 64'(1) << id);
      @(posedge clk); #1;
      req_valid = '0;
      last_grant = id;
   endtask

   // Count RUN cycles from the handshake edge until the response appears
   task automatic wait_resp(output int lat);
      lat = 0;
      while (!resp_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!resp_valid) check("resp_timeout", 0, 1);
   endtask

   task automatic release_resp();
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("idle_after_release", busy, 0);
   endtask

   task automatic run_and_check(input string tag, input int id, input int a, input int b,
                                input bit ct, input int exp_o, input int exp_cyc);
      int lat;
      start_op(id, a, b, ct);
      wait_resp(lat);
      check({tag, "_o"}, resp_o, exp_o);
      check({tag, "_id"}, resp_id, id);
      check({tag, "_cycles"}, resp_cycles, exp_cyc);
      check({tag, "_latency"}, lat, exp_cyc);
      release_resp();
   endtask

   initial begin
      vec_t vecs[9];
      int lat;
      int exp_g;
      int n;
      int ra, rb, rid;
      bit rct;
      logic [WIDTH-1:0] opa [NUM_REQ];
      logic [WIDTH-1:0] opb [NUM_REQ];

      vecs[0] = '{0, 3, 5, 1'b0, 15, 4};
      vecs[1] = '{1, 7, 0, 1'b0, 0, 1};
      vecs[2] = '{1, 7, 0, 1'b1, 0, 5};
      vecs[3] = '{0, 15, 15, 1'b0, 225, 5};
      vecs[4] = '{1, 0, 9, 1'b0, 0, 1};
      vecs[5] = '{0, 1, 1, 1'b0, 1, 2};
      vecs[6] = '{1, 8, 8, 1'b0, 64, 5};
      vecs[7] = '{0, 15, 15, 1'b1, 225, 5};
      vecs[8] = '{1, 2, 1, 1'b1, 2, 5};

      rst_n = 1'b0;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      req_const_time = '0;
      resp_ready = 1'b0;
      last_grant = NUM_REQ - 1;
      repeat (2) @(negedge clk);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_resp_o", resp_o, 0);
      check("rst_resp_id", resp_id, 0);
      check("rst_resp_cycles", resp_cycles, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;

      // Fixed vector table
      for (int i = 0; i < 9; i++)
         run_and_check($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b,
                       vecs[i].ct, vecs[i].exp_o, vecs[i].exp_cyc);

      // Exhaustive sweep in both modes against the model
      for (int ct = 0; ct < 2; ct++)
         for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
               run_and_check($sformatf("sweep_ct%0d_%0dx%0d", ct, a, b), (a + b) % NUM_REQ,
                             a, b, ct[0], a * b, model_cycles(a, b, ct[0]));

      // Randomized operations
      for (int i = 0; i < 120; i++) begin
         rid = $urandom_range(NUM_REQ - 1, 0);
         ra  = $urandom_range(15, 0);
         rb  = $urandom_range(15, 0);
         rct = $urandom_range(1, 0);
         run_and_check($sformatf("rand%0d", i), rid, ra, rb, rct, ra * rb, model_cycles(ra, rb, rct));
      end

      // Response stall: outputs hold, no new grant while DONE
      start_op(0, 9, 11, 1'b0);
      wait_resp(lat);
      @(negedge clk);
      req_valid[1] = 1'b1;
      req_a[WIDTH +: WIDTH] = 4'd2;
      req_b[WIDTH +: WIDTH] = 4'd3;
      req_const_time[1] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("stall_valid", resp_valid, 1);
         check("stall_o", resp_o, 99);
         check("stall_id", resp_id, 0);
         check("stall_cycles", resp_cycles, 5);
         check("stall_req_ready", req_ready, 0);
         @(negedge clk);
      end
      resp_ready = 1'b1;
      req_valid = '0;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("stall_release_busy", busy, 0);
      check("stall_release_valid", resp_valid, 0);
      check("stall_hold_o", resp_o, 99);
      check("stall_hold_cycles", resp_cycles, 5);

      // Reset in the middle of RUN discards the operation
      start_op(1, 15, 15, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", resp_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_o", resp_o, 0);
      check("midrst_id", resp_id, 0);
      check("midrst_cycles", resp_cycles, 0);
      check("midrst_req_ready", req_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      last_grant = NUM_REQ - 1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("post_rst_no_resp", resp_valid, 0);
      end

      // Both requesters held high: strict alternation starting at requester 0
      opa[0] = 4'd3; opb[0] = 4'd2;
      opa[1] = 4'd6; opb[1] = 4'd7;
      req_a = {opa[1], opa[0]};
      req_b = {opb[1], opb[0]};
      req_const_time = '0;
      req_valid = '1;
      for (int op = 0; op < 4; op++) begin
         exp_g = (last_grant + 1) % NUM_REQ;
         #1;
         n = 0;
         while (req_ready == '0 && n < 20) begin
            @(negedge clk); #1;
            n++;
         end
         check($sformatf("rr%0d_onehot", op), $countones(req_ready), 1);
         check($sformatf("rr%0d_grant", op), req_ready, 64'(1) << exp_g);
         @(posedge clk); #1;
         wait_resp(lat);
         check($sformatf("rr%0d_ready_low", op), req_ready, 0);
         check($sformatf("rr%0d_id", op), resp_id, exp_g);
         check($sformatf("rr%0d_o", op), resp_o, opa[exp_g] * opb[exp_g]);
         last_grant = exp_g;
         release_resp();
         @(negedge clk);
      end
      req_valid = '0;

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mul_share_sched.md
Name: mul_share_sched

Overview:
- Round-robin scheduler that time-shares one iterative shift-and-add multiplier among NUM_REQ requesters.
- Each requester uses a valid/ready handshake; a single response channel returns the product, the winning requester index and the consumed cycle count.
- A per-request const_time bit disables the zero-operand early-termination shortcut, so latency becomes data-independent. This supports contract-style timing-leak checking of the shared unit.

Parameters:
WIDTH, 4, operand width in bits (power of two, >=2)
NUM_REQ, 2, number of requesters (>=2)
ID_W, $clog2(NUM_REQ), width of requester index
CNT_W, $clog2(WIDTH)+1, width of iteration counter and cycle report

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept strobe (one-hot or zero)
req_a  in  NUM_REQ*WIDTH  packed multiplicands, requester i at [i*WIDTH +: WIDTH]
req_b  in  NUM_REQ*WIDTH  packed multipliers, same packing
req_const_time  in  NUM_REQ  per-requester constant-time mode bit
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_o  out  2*WIDTH  product a*b
resp_id  out  ID_W  index of requester that issued the operation
resp_cycles  out  CNT_W+1  number of RUN cycles spent
busy  out  1  high in RUN or DONE

Behaviour:
- Reset (async assert, sync-to-clk deassert not required inside block):
  - state=IDLE; a_reg, b_reg, o_reg, counter, cycles, id_reg, ct_reg = 0.
  - rr_ptr = NUM_REQ-1, so requester 0 has first priority.
  - Outputs: req_ready=0, resp_valid=0, resp_o=0, resp_id=0, resp_cycles=0, busy=0.
  - Reset mid-operation discards the in-flight operation; no response is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Grant = first i with req_valid[i], searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - req_ready[grant]=1 combinationally; all other bits 0. req_ready=0 in RUN and DONE.
  - On handshake edge: a_reg=req_a[grant], b_reg=req_b[grant], ct_reg=req_const_time[grant], id_reg=grant, o_reg=0, counter=0, cycles=0, rr_ptr=grant, state=RUN.
  - No valid request: stay in IDLE; rr_ptr unchanged.
- RUN (every cycle, cycles += 1):
  - Exit check, evaluated first:
    - ct_reg=0 and (a_reg==0 or b_reg==0): state=DONE, no datapath update.
    - ct_reg=1 and counter==WIDTH: state=DONE, no datapath update.
  - Otherwise: o_reg += b_reg[0] ? (zero-extended a_reg << counter) : 0; b_reg >>= 1; counter += 1.
  - o_reg is 2*WIDTH bits wide and cannot overflow.
  - The cycle count includes the exit-check cycle.
- RUN latency:
  - Early mode: 1 cycle if a==0 or b==0; otherwise msb_index(b)+2.
  - Const-time mode: WIDTH+1 for all operands.
- DONE:
  - resp_valid=1; resp_o=o_reg, resp_id=id_reg, resp_cycles=cycles, all held stable until handshake.
  - resp_valid & resp_ready at edge: state=IDLE. A new request is accepted no earlier than the next cycle, since req_ready is 0 during DONE.
  - While resp_valid=0, resp_o/resp_id/resp_cycles still show the last completed values (0 after reset).
- Requester-side rules:
  - Dropping req_valid before the handshake is allowed.
  - Operands are sampled only at the handshake.
- Simultaneous valid requests: exactly one grant per IDLE visit, in strict round-robin order.
- busy = (state != IDLE).

Test Plan:
- Reset, then req0 a=3, b=5, const_time=0 -> handshake cycle 1; RUN 4 cycles; resp_valid with resp_o=15, resp_id=0, resp_cycles=4.
- req1 a=7, b=0, early mode -> resp_cycles=1, resp_o=0; same operands with const_time=1 -> resp_cycles=5 (WIDTH=4), resp_o=0.
- Const-time sweep over all a,b in 0..15 -> resp_o=a*b and resp_cycles=5 for every pair; early mode -> cycles match the formula.
- Both req_valid held high for 4 operations -> grants ordered 0,1,0,1; req_ready is never multi-hot; each response's resp_id matches the grant.
- resp_ready held low 3 cycles in DONE -> resp_valid, resp_o, resp_id, resp_cycles stable; req_ready=0 throughout; IDLE is entered the cycle after resp_ready rises.
- rst_n asserted mid-RUN (a=15, b=15) -> outputs immediately 0, state IDLE, no resp_valid after release; next request from req0 is granted first.
